key_expand_ctrl: RTL and testbench

Sequential AES-128 key expansion engine. Accepts a 128-bit cipher key over a valid/ready handshake, then iterates the combinational `key_schedule` round function once per clock to produce round keys 0..10. It stores all eleven round keys and serves them to the round datapath through a registered random-access read port.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/key_schedule.sv | 73 +++++++
 rtl/key_expand_ctrl.sv | 119 +++++++++++
 tb/tb_key_expand_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion types, constants and the GF(2^8) xtime helper.
// Imported by key_schedule and key_expand_ctrl.
package aes_pkg;

  localparam int         AES_NR        = 10;
  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_RCON_POLY = 8'h1B;

  typedef enum logic {
    IDLE,
    EXPAND
  } state_t;

  typedef logic [127:0] round_key_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule.sv
// One AES-128 key-schedule round: next round key from the current one.
// Ports: i_key (current key), i_rcon ({24'h0,rc}), o_key (next key).
module key_schedule
  import aes_pkg::*;
(
  input  round_key_t  i_key,
  input  logic [31:0] i_rcon,
  output round_key_t  o_key
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from first principles: x^254 is the
  // field inverse (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] x
  );
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^
           {inv[6:0], inv[7]} ^
           {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^
           8'h63;
  endfunction

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot;
  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = i_key[31:0];
  assign w_w1 = i_key[63:32];
  assign w_w2 = i_key[95:64];
  assign w_w3 = i_key[127:96];

  // Byte 0 sits in the low bits, so RotWord is a
  // numeric rotate right by one byte.
  assign w_rot = {w_w3[7:0], w_w3[31:8]};

  assign w_t = {sbox(w_rot[31:24]),
                sbox(w_rot[23:16]),
                sbox(w_rot[15:8]),
                sbox(w_rot[7:0])} ^ i_rcon;

  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_key = {w_n3, w_n2, w_n1, w_n0};

endmodule

// File: rtl/key_expand_ctrl.sv
// Sequential AES-128 key expansion: one round per clock, 11 stored keys.
// Ports: clk, rst (async high), key_in/key_valid/key_ready handshake,
// busy, keys_valid, rk_idx -> rk_out (registered read, 1 cycle).
// Option KEY_EXPAND_ZEROIZE_EN adds input zeroize (sync clear + abort).
module key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
`ifdef KEY_EXPAND_ZEROIZE_EN
  input  logic         zeroize,
`endif
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  state_t     r_state;
  state_t     w_state_nxt;
  round_key_t r_rk [0:NR];
  round_key_t r_work;
  round_key_t w_next;
  round_key_t w_rd;
  logic [7:0] r_rc;
  logic [3:0] r_rnd;
  logic       r_keys_valid;
  round_key_t r_rk_out;
  logic       w_accept;
  logic       w_last;
  logic       w_zero;

`ifdef KEY_EXPAND_ZEROIZE_EN
  assign w_zero = zeroize;
`else
  assign w_zero = 1'b0;
`endif

  key_schedule u_ks (
    .i_key  (r_work),
    .i_rcon ({24'h0, r_rc}),
    .o_key  (w_next)
  );

  assign busy       = (r_state == EXPAND);
  // Zeroize wins over a simultaneous accept.
  assign key_ready  = !busy && !w_zero;
  assign keys_valid = r_keys_valid;
  assign rk_out     = r_rk_out;

  assign w_rd = (rk_idx <= 4'(NR)) ?
                r_rk[rk_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (key_valid && key_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        if (r_rnd == 4'(NR)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_zero) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++)
        r_rk[i] <= '0;
      r_work       <= '0;
      r_rc         <= AES_RCON_INIT;
      r_rnd        <= 4'd0;
      r_keys_valid <= 1'b0;
      r_rk_out     <= '0;
    end else if (w_zero) begin
      for (int i = 0; i <= NR; i++)
        r_rk[i] <= '0;
      r_work       <= '0;
      r_keys_valid <= 1'b0;
      r_rk_out     <= '0;
    end else begin
      if (w_accept) begin
        r_rk[0]      <= key_in;
        r_work       <= key_in;
        r_rc         <= AES_RCON_INIT;
        r_rnd        <= 4'd1;
        r_keys_valid <= 1'b0;
      end else if (busy) begin
        r_rk[r_rnd] <= w_next;
        r_work      <= w_next;
        r_rc        <= xtime(r_rc);
        r_rnd       <= r_rnd + 4'd1;
        if (w_last) r_keys_valid <= 1'b1;
      end
      r_rk_out <= w_rd;
    end
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// Directed self-checking bench for key_expand_ctrl.
// Expected round keys are FIPS-197 published vectors.
module tb_key_expand_ctrl;

  logic         clk;
  logic         rst;
  logic         zeroize;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int total;
  int bad;

  key_expand_ctrl dut (
    .clk        (clk),
    .rst        (rst),
`ifdef KEY_EXPAND_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vectors are written byte 0 first; swap into the
  // byte-0-at-LSB port layout.
  function automatic logic [127:0] bs(
    input logic [127:0] v
  );
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  logic [127:0] fips [0:10];
  logic [127:0] zk1;
  logic [127:0] zk10;

  task automatic load_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_kv(output logic ok);
    int n;
    n = 0;
    while (!keys_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    ok = keys_valid;
  endtask

  task automatic read_rk(
    input  logic [3:0]   idx,
    output logic [127:0] v
  );
    rk_idx = idx;
    @(posedge clk); #1;
    v = rk_out;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    total++;
    if (keys_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_kv got=%b exp=0", keys_valid);
    end
    total++;
    if (key_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", key_ready);
    end
    total++;
    if (rk_out !== 128'h0) begin
      bad++;
      $display("FAIL reset_rkout got=%h exp=0", rk_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fips;
    int cnt;
    logic ok;
    logic [127:0] v;
    load_key(fips[0]);
    cnt = 0;
    while (busy && cnt < 20) begin
      total++;
      if (keys_valid !== 1'b0) begin
        bad++;
        $display("FAIL fips_kv_early cyc=%0d got=1", cnt);
      end
      @(posedge clk); #1;
      cnt++;
    end
    total++;
    if (cnt != 10) begin
      bad++;
      $display("FAIL fips_busy_len got=%0d exp=10", cnt);
    end
    wait_kv(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL fips_kv got=%b exp=1", ok);
    end
    total++;
    if (key_ready !== 1'b1) begin
      bad++;
      $display("FAIL fips_ready got=%b exp=1", key_ready);
    end
    read_rk(4'd1, v);
    total++;
    if (v !== fips[1]) begin
      bad++;
      $display("FAIL fips_rk1 got=%h exp=%h", v, fips[1]);
    end
    read_rk(4'd10, v);
    total++;
    if (v !== fips[10]) begin
      bad++;
      $display("FAIL fips_rk10 got=%h exp=%h", v, fips[10]);
    end
  endtask

  task automatic test_read_port;
    logic [3:0]   idx [0:12];
    logic [127:0] exp;
    for (int i = 0; i <= 10; i++) idx[i] = 4'(i);
    idx[11] = 4'd11;
    idx[12] = 4'd15;
    rk_idx = idx[0];
    for (int i = 0; i <= 12; i++) begin
      @(posedge clk); #1;
      exp = (i <= 10) ? fips[i] : 128'h0;
      total++;
      if (rk_out !== exp) begin
        bad++;
        $display("FAIL read_idx%0d got=%h exp=%h",
                 idx[i], rk_out, exp);
      end
      if (i < 12) rk_idx = idx[i+1];
    end
  endtask

  task automatic test_zero_key;
    logic ok;
    logic [127:0] v;
    load_key(128'h0);
    wait_kv(ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL zero_kv got=%b exp=1", ok);
    end
    read_rk(4'd1, v);
    total++;
    if (v !== zk1) begin
      bad++;
      $display("FAIL zero_rk1 got=%h exp=%h", v, zk1);
    end
    read_rk(4'd10, v);
    total++;
    if (v !== zk10) begin
      bad++;
      $display("FAIL zero_rk10 got=%h exp=%h", v, zk10);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    logic rdy;
    logic ok;
    logic [127:0] v;
    load_key(fips[0]);
    key_in    = 128'h0;
    key_valid = 1'b1;
    k = 0;
    rdy = 1'b0;
    while (!rdy && k < 30) begin
      rdy = key_ready;
      @(posedge clk); #1;
      k++;
    end
    key_valid = 1'b0;
    total++;
    if (k < 10 || !rdy) begin
      bad++;
      $display("FAIL b2b_accept_edge got=%0d exp>=10", k);
    end
    total++;
    if (busy !== 1'b1 || keys_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_started got=%b%b exp=10",
               busy, keys_valid);
    end
    wait_kv(ok);
    read_rk(4'd1, v);
    total++;
    if (v !== zk1) begin
      bad++;
      $display("FAIL b2b_rk1 got=%h exp=%h", v, zk1);
    end
    read_rk(4'd10, v);
    total++;
    if (v !== zk10) begin
      bad++;
      $display("FAIL b2b_rk10 got=%h exp=%h", v, zk10);
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic [127:0] v;
    rk_idx = 4'd0;
    load_key(fips[0]);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || keys_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_flags got=%b%b exp=00",
               busy, keys_valid);
    end
    total++;
    if (rk_out !== 128'h0) begin
      bad++;
      $display("FAIL mid_rst_rkout got=%h exp=0", rk_out);
    end
    total++;
    if (key_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_ready got=%b exp=1", key_ready);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    read_rk(4'd0, v);
    total++;
    if (v !== 128'h0) begin
      bad++;
      $display("FAIL mid_rst_rk0 got=%h exp=0", v);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_noresume got=%b exp=0", busy);
    end
    load_key(fips[0]);
    wait_kv(ok);
    read_rk(4'd5, v);
    total++;
    if (v !== fips[5]) begin
      bad++;
      $display("FAIL mid_rst_rk5 got=%h exp=%h", v, fips[5]);
    end
    read_rk(4'd10, v);
    total++;
    if (v !== fips[10]) begin
      bad++;
      $display("FAIL mid_rst_rk10 got=%h exp=%h", v, fips[10]);
    end
  endtask

`ifdef KEY_EXPAND_ZEROIZE_EN
  task automatic test_zeroize;
    logic [127:0] v;
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    total++;
    if (keys_valid !== 1'b0) begin
      bad++;
      $display("FAIL zz_kv got=%b exp=0", keys_valid);
    end
    for (int i = 0; i <= 10; i += 5) begin
      read_rk(4'(i), v);
      total++;
      if (v !== 128'h0) begin
        bad++;
        $display("FAIL zz_rk%0d got=%h exp=0", i, v);
      end
    end
    load_key(fips[0]);
    repeat (2) begin
      @(posedge clk); #1;
    end
    zeroize   = 1'b1;
    key_in    = 128'h0;
    key_valid = 1'b1;
    #1;
    total++;
    if (key_ready !== 1'b0) begin
      bad++;
      $display("FAIL zz_ready got=%b exp=0", key_ready);
    end
    @(posedge clk); #1;
    zeroize   = 1'b0;
    key_valid = 1'b0;
    total++;
    if (busy !== 1'b0 || keys_valid !== 1'b0) begin
      bad++;
      $display("FAIL zz_abort got=%b%b exp=00",
               busy, keys_valid);
    end
  endtask
`endif

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    zeroize   = 1'b0;
    key_in    = '0;
    key_valid = 1'b0;
    rk_idx    = 4'd0;
    fips[0]  = bs(128'h2b7e151628aed2a6abf7158809cf4f3c);
    fips[1]  = bs(128'ha0fafe1788542cb123a339392a6c7605);
    fips[2]  = bs(128'hf2c295f27a96b9435935807a7359f67f);
    fips[3]  = bs(128'h3d80477d4716fe3e1e237e446d7a883b);
    fips[4]  = bs(128'hef44a541a8525b7fb671253bdb0bad00);
    fips[5]  = bs(128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    fips[6]  = bs(128'h6d88a37a110b3efddbf98641ca0093fd);
    fips[7]  = bs(128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
    fips[8]  = bs(128'head27321b58dbad2312bf5607f8d292f);
    fips[9]  = bs(128'hac7766f319fadc2128d12941575c006e);
    fips[10] = bs(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    zk1  = bs(128'h62636363626363636263636362636363);
    zk10 = bs(128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    test_reset;
    test_fips;
    test_read_port;
    test_zero_key;
    test_back_to_back;
    test_reset_mid;
`ifdef KEY_EXPAND_ZEROIZE_EN
    test_zeroize;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
